// File: rtl/pipe_dmem_arbiter.sv
// pipe_dmem_arbiter: shares the single-port data RAM between the MEM stage and a
// debug/loader port. The CPU owns the RAM by default; a debug access takes an idle
// MEM cycle, or is forced after MAX_WAIT blocked cycles by stalling the pipeline once.
// Optional statistics counters are built only when DMEM_ARB_STATS_EN is defined.
module pipe_dmem_arbiter #(
    parameter int unsigned AW       = 8,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [31:0]   cpu_wdata,
    output logic [31:0]   cpu_rdata,
    output logic          cpu_stall,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [31:0]   dbg_wdata,
    output logic          dbg_ack,
    output logic [31:0]   dbg_rdata,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [31:0]   ram_wdata,
    input  logic [31:0]   ram_rdata,
    output logic [15:0]   stat_stall,
    output logic [15:0]   stat_dgnt
);

    typedef enum logic {
        S_CPU,
        S_DBG
    } state_t;

    localparam logic [2:0] WAIT_LAST = 3'(MAX_WAIT - 1);

    state_t     state;
    logic [2:0] wait_cnt;

    // Ownership FSM: count blocked debug cycles, grant debug for exactly one cycle
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state    <= S_CPU;
            wait_cnt <= '0;
        end else begin
            case (state)
                S_CPU: begin
                    if (dbg_req) begin
                        if (!cpu_req || wait_cnt == WAIT_LAST) begin
                            state    <= S_DBG;
                            wait_cnt <= '0;
                        end else begin
                            wait_cnt <= wait_cnt + 3'd1;
                        end
                    end else begin
                        wait_cnt <= '0;
                    end
                end
                S_DBG: begin
                    state    <= S_CPU;
                    wait_cnt <= '0;
                end
                default: begin
                    state    <= S_CPU;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    // RAM port steering and handshake decode from the registered owner only
    always_comb begin
        cpu_rdata = ram_rdata;
        dbg_rdata = ram_rdata;
        if (state == S_DBG) begin
            ram_we    = dbg_we;
            ram_addr  = dbg_addr;
            ram_wdata = dbg_wdata;
            dbg_ack   = 1'b1;
            cpu_stall = cpu_req;
        end else begin
            ram_we    = cpu_req & cpu_we;
            ram_addr  = cpu_addr;
            ram_wdata = cpu_wdata;
            dbg_ack   = 1'b0;
            cpu_stall = 1'b0;
        end
    end

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] stall_q;
    logic [15:0] dgnt_q;

    // Saturating stall-cycle and debug-grant counters
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            stall_q <= '0;
            dgnt_q  <= '0;
        end else begin
            if (cpu_stall && stall_q != 16'hFFFF) begin
                stall_q <= stall_q + 16'd1;
            end
            if (dbg_ack && dgnt_q != 16'hFFFF) begin
                dgnt_q <= dgnt_q + 16'd1;
            end
        end
    end

    assign stat_stall = stall_q;
    assign stat_dgnt  = dgnt_q;
`else
    assign stat_stall = '0;
    assign stat_dgnt  = '0;
`endif

endmodule
